// File: rtl/fft_lane_pipe.sv
// Flow-controlled, bubble-collapsing I/Q pipeline for the FFT datapath.
// One shared valid/advance chain steers the per-lane data stage registers.

module fft_lane_stages #(
  parameter int DATA_WIDTH = 9,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [DEPTH-1:0]             ld,
  input  logic signed [DATA_WIDTH-1:0] in_i,
  input  logic signed [DATA_WIDTH-1:0] in_q,
  output logic signed [DATA_WIDTH-1:0] out_i,
  output logic signed [DATA_WIDTH-1:0] out_q
);
  logic [DEPTH-1:0][DATA_WIDTH-1:0] si, sq;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      si <= '0;
      sq <= '0;
    end else begin
      if (ld[0]) begin
        si[0] <= in_i;
        sq[0] <= in_q;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (ld[k]) begin
          si[k] <= si[k-1];
          sq[k] <= sq[k-1];
        end
      end
    end
  end

  assign out_i = $signed(si[DEPTH-1]);
  assign out_q = $signed(sq[DEPTH-1]);
endmodule

module fft_lane_pipe #(
  parameter int DATA_WIDTH = 9,
  parameter int NUM_LANES  = 16,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH+1)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] din_i [0:NUM_LANES-1],
  input  logic signed [DATA_WIDTH-1:0] din_q [0:NUM_LANES-1],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] dout_i [0:NUM_LANES-1],
  output logic signed [DATA_WIDTH-1:0] dout_q [0:NUM_LANES-1],
  output logic [CNT_W-1:0]             occupancy
);
  logic [DEPTH-1:0] vld_pipe, adv, vin, ld;
  logic             tail, accept, emit;

  // A stage may advance unless it and every stage downstream of it are full
  // while the output is stalled; computed as a running AND to keep it acyclic.
  always_comb begin
    tail = 1'b1;
    adv  = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      tail   = tail & vld_pipe[k];
      adv[k] = !tail || out_ready;
    end
  end

  assign in_ready  = adv[0] && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_pipe[DEPTH-1];
  assign emit      = out_valid && out_ready;

  always_comb begin
    vin    = '0;
    vin[0] = accept;
    for (int k = 1; k < DEPTH; k++) vin[k] = vld_pipe[k-1];
  end

  // Data only moves with a valid beat; bubbles shift valid bits only.
  assign ld = adv & vin & {DEPTH{!flush}};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      vld_pipe <= '0;
    else if (flush) vld_pipe <= '0;
    else begin
      for (int k = 0; k < DEPTH; k++)
        if (adv[k]) vld_pipe[k] <= vin[k];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      occupancy <= '0;
    else if (flush) occupancy <= '0;
    else if (accept && !emit) occupancy <= occupancy + CNT_W'(1);
    else if (!accept && emit) occupancy <= occupancy - CNT_W'(1);
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    fft_lane_stages #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_lane (
      .clk   (clk),
      .rstn  (rstn),
      .ld    (ld),
      .in_i  (din_i[l]),
      .in_q  (din_q[l]),
      .out_i (dout_i[l]),
      .out_q (dout_q[l])
    );
  end
endmodule

// File: tb/tb_fft_lane_pipe.sv
// Bench for fft_lane_pipe: DEPTH=4/16-lane build and DEPTH=1/2-lane build,
// scoreboarded on accepted beats, with per-scenario checks.

module tb_fft_lane_pipe;
  localparam int DW = 9;
  localparam int NA = 16;
  localparam int DA = 4;
  localparam int NB = 2;
  localparam int DB = 1;

  logic clk = 0, rstn = 0;
  always #5 clk = ~clk;

  logic flush, in_valid, in_ready, out_valid, out_ready;
  logic signed [DW-1:0] din_i [0:NA-1], din_q [0:NA-1];
  logic signed [DW-1:0] dout_i[0:NA-1], dout_q[0:NA-1];
  logic [2:0] occupancy;

  logic b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic signed [DW-1:0] b_din_i [0:NB-1], b_din_q [0:NB-1];
  logic signed [DW-1:0] b_dout_i[0:NB-1], b_dout_q[0:NB-1];
  logic [0:0] b_occupancy;

  fft_lane_pipe #(.DATA_WIDTH(DW), .NUM_LANES(NA), .DEPTH(DA)) dut_a (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .din_i(din_i), .din_q(din_q), .out_valid(out_valid), .out_ready(out_ready),
    .dout_i(dout_i), .dout_q(dout_q), .occupancy(occupancy));

  fft_lane_pipe #(.DATA_WIDTH(DW), .NUM_LANES(NB), .DEPTH(DB)) dut_b (
    .clk(clk), .rstn(rstn), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .din_i(b_din_i), .din_q(b_din_q), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .dout_i(b_dout_i), .dout_q(b_dout_q), .occupancy(b_occupancy));

  int nvec = 0, nerr = 0;
  logic [NA*DW-1:0] sb_ai[$], sb_aq[$];
  logic [NB*DW-1:0] sb_bi[$], sb_bq[$];
  int occ_a = 0, occ_b = 0;

  function automatic logic [NA*DW-1:0] pk_a(input logic signed [DW-1:0] a [0:NA-1]);
    logic [NA*DW-1:0] r;
    for (int j = 0; j < NA; j++) r[j*DW +: DW] = a[j];
    return r;
  endfunction

  function automatic logic [NB*DW-1:0] pk_b(input logic signed [DW-1:0] a [0:NB-1]);
    logic [NB*DW-1:0] r;
    for (int j = 0; j < NB; j++) r[j*DW +: DW] = a[j];
    return r;
  endfunction

  // Beat n, lane j: I = n*16+j, Q = -(n*16+j); beat 11 carries the Q = -256 extreme.
  task automatic set_beat(input int n);
    for (int j = 0; j < NA; j++) begin
      if (n == 11) begin
        din_i[j] = 9'sd255;
        din_q[j] = -9'sd256;
      end else begin
        din_i[j] = 9'(n*16 + j);
        din_q[j] = 9'(-(n*16 + j));
      end
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Scoreboard / occupancy model for the DEPTH=4 build.
  always @(negedge clk) begin
    logic exp_rdy;
    logic [NA*DW-1:0] ei, eq;
    if (!rstn) begin
      sb_ai.delete(); sb_aq.delete(); occ_a = 0;
    end else begin
      exp_rdy = !flush && (occ_a < DA || out_ready);
      nvec++;
      if (in_ready !== exp_rdy) begin
        nerr++; $display("FAIL a_in_ready: got %b want %b", in_ready, exp_rdy);
      end
      nvec++;
      if (occupancy !== 3'(occ_a)) begin
        nerr++; $display("FAIL a_occupancy: got %0d want %0d", occupancy, occ_a);
      end
      if (out_valid && out_ready) begin
        nvec++;
        if (sb_ai.size() == 0) begin
          nerr++; $display("FAIL a_unexpected_beat: got out_valid=1 want no beat pending");
        end else begin
          ei = sb_ai.pop_front(); eq = sb_aq.pop_front();
          if (pk_a(dout_i) !== ei || pk_a(dout_q) !== eq) begin
            nerr++; $display("FAIL a_beat_data: got i=%h q=%h want i=%h q=%h",
                             pk_a(dout_i), pk_a(dout_q), ei, eq);
          end
        end
      end
      if (in_valid && exp_rdy) begin
        sb_ai.push_back(pk_a(din_i)); sb_aq.push_back(pk_a(din_q));
      end
      if (flush) begin
        sb_ai.delete(); sb_aq.delete(); occ_a = 0;
      end else begin
        occ_a = occ_a + int'(in_valid && exp_rdy) - int'(out_valid && out_ready);
      end
    end
  end

  // Scoreboard / occupancy model for the DEPTH=1 build.
  always @(negedge clk) begin
    logic exp_rdy;
    logic [NB*DW-1:0] ei, eq;
    if (!rstn) begin
      sb_bi.delete(); sb_bq.delete(); occ_b = 0;
    end else begin
      exp_rdy = !b_flush && (occ_b < DB || b_out_ready);
      nvec++;
      if (b_in_ready !== exp_rdy) begin
        nerr++; $display("FAIL b_in_ready: got %b want %b", b_in_ready, exp_rdy);
      end
      if (b_out_valid && b_out_ready) begin
        nvec++;
        if (sb_bi.size() == 0) begin
          nerr++; $display("FAIL b_unexpected_beat: got out_valid=1 want no beat pending");
        end else begin
          ei = sb_bi.pop_front(); eq = sb_bq.pop_front();
          if (pk_b(b_dout_i) !== ei || pk_b(b_dout_q) !== eq) begin
            nerr++; $display("FAIL b_beat_data: got i=%h q=%h want i=%h q=%h",
                             pk_b(b_dout_i), pk_b(b_dout_q), ei, eq);
          end
        end
      end
      if (b_in_valid && exp_rdy) begin
        sb_bi.push_back(pk_b(b_din_i)); sb_bq.push_back(pk_b(b_din_q));
      end
      occ_b = occ_b + int'(b_in_valid && exp_rdy) - int'(b_out_valid && b_out_ready);
    end
  end

  task automatic test_reset;
    rstn = 0; flush = 0; in_valid = 0; out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0;
    for (int j = 0; j < NA; j++) begin din_i[j] = 9'($urandom); din_q[j] = 9'($urandom); end
    for (int j = 0; j < NB; j++) begin b_din_i[j] = 9'($urandom); b_din_q[j] = 9'($urandom); end
    repeat (2) @(negedge clk);
    nvec++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0 || in_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_ctrl: got v=%b occ=%0d rdy=%b want v=0 occ=0 rdy=1",
                       out_valid, occupancy, in_ready);
    end
    nvec++;
    if (pk_a(dout_i) !== '0 || pk_a(dout_q) !== '0) begin
      nerr++; $display("FAIL reset_dout: got i=%h q=%h want 0", pk_a(dout_i), pk_a(dout_q));
    end
    nvec++;
    if (b_out_valid !== 1'b0 || b_occupancy !== 1'b0 || b_in_ready !== 1'b1 ||
        pk_b(b_dout_i) !== '0 || pk_b(b_dout_q) !== '0) begin
      nerr++; $display("FAIL reset_b: got v=%b occ=%0d rdy=%b want v=0 occ=0 rdy=1 dout=0",
                       b_out_valid, b_occupancy, b_in_ready);
    end
    tick;
    rstn = 1;
    tick;
  endtask

  task automatic test_stream;
    out_ready = 1; in_valid = 1; set_beat(0);
    tick;
    in_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      nvec++;
      if (out_valid !== (k == 3)) begin
        nerr++; $display("FAIL latency_edge%0d: got out_valid=%b want %b", k+1, out_valid, k == 3);
      end
    end
    tick;
    for (int n = 1; n <= 11; n++) begin
      set_beat(n); in_valid = 1;
      tick;
    end
    in_valid = 0;
    repeat (DA + 2) tick;
    @(negedge clk);
    nvec++;
    if (sb_ai.size() != 0 || occupancy !== 3'd0 || out_valid !== 1'b0) begin
      nerr++; $display("FAIL stream_drain: got pending=%0d occ=%0d v=%b want 0 0 0",
                       sb_ai.size(), occupancy, out_valid);
    end
    tick;
  endtask

  task automatic test_full_stall;
    logic ok;
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      set_beat(20 + i); in_valid = 1;
      @(negedge clk);
      nvec++;
      if (in_ready !== (i < 4)) begin
        nerr++; $display("FAIL stall_ready%0d: got %b want %b", i, in_ready, i < 4);
      end
      tick;
    end
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      ok = 1;
      for (int j = 0; j < NA; j++)
        if (dout_i[j] !== 9'(320 + j) || dout_q[j] !== 9'(-(320 + j))) ok = 0;
      nvec++;
      if (!ok || out_valid !== 1'b1 || occupancy !== 3'd4 || in_ready !== 1'b0) begin
        nerr++; $display("FAIL stall_hold%0d: got ok=%b v=%b occ=%0d rdy=%b want 1 1 4 0",
                         r, ok, out_valid, occupancy, in_ready);
      end
      tick;
    end
    in_valid = 0; out_ready = 1;
    repeat (6) tick;
    @(negedge clk);
    nvec++;
    if (sb_ai.size() != 0 || occupancy !== 3'd0) begin
      nerr++; $display("FAIL stall_drain: got pending=%0d occ=%0d want 0 0", sb_ai.size(), occupancy);
    end
    tick;
  endtask

  task automatic test_bubble;
    out_ready = 0;
    for (int n = 40; n < 42; n++) begin
      set_beat(n); in_valid = 1;
      tick;
    end
    in_valid = 0;
    repeat (4) tick;
    @(negedge clk);
    nvec++;
    if (occupancy !== 3'd2 || in_ready !== 1'b1 || out_valid !== 1'b1 || dut_a.vld_pipe !== 4'b1100) begin
      nerr++; $display("FAIL bubble_collapse: got occ=%0d rdy=%b v=%b vld=%b want 2 1 1 1100",
                       occupancy, in_ready, out_valid, dut_a.vld_pipe);
    end
    tick;
    out_ready = 1;
    tick;
    out_ready = 0;
    @(negedge clk);
    nvec++;
    if (out_valid !== 1'b1 || dout_i[0] !== 9'(41*16) || occupancy !== 3'd1) begin
      nerr++; $display("FAIL bubble_next: got v=%b i0=%0d occ=%0d want 1 %0d 1",
                       out_valid, dout_i[0], occupancy, 41*16);
    end
    tick;
    out_ready = 1;
    repeat (3) tick;
  endtask

  task automatic test_flush;
    out_ready = 0;
    for (int n = 60; n < 64; n++) begin
      set_beat(n); in_valid = 1;
      tick;
    end
    set_beat(64); in_valid = 1; flush = 1;
    @(negedge clk);
    nvec++;
    if (in_ready !== 1'b0) begin
      nerr++; $display("FAIL flush_ready: got %b want 0", in_ready);
    end
    tick;
    flush = 0; in_valid = 0;
    @(negedge clk);
    nvec++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
      nerr++; $display("FAIL flush_clear: got v=%b occ=%0d want 0 0", out_valid, occupancy);
    end
    tick;
    out_ready = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      nvec++;
      if (out_valid !== 1'b0) begin
        nerr++; $display("FAIL flush_ghost%0d: got out_valid=%b want 0", c, out_valid);
      end
      tick;
    end
    // Flush coinciding with an output handshake.
    for (int n = 70; n < 74; n++) begin
      set_beat(n); in_valid = 1;
      tick;
    end
    in_valid = 0; flush = 1;
    @(negedge clk);
    nvec++;
    if (out_valid !== 1'b1 || dout_i[0] !== 9'(70*16)) begin
      nerr++; $display("FAIL flush_out_hs: got v=%b i0=%0d want 1 %0d", out_valid, dout_i[0], 70*16);
    end
    tick;
    flush = 0;
    repeat (5) begin
      @(negedge clk);
      nvec++;
      if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
        nerr++; $display("FAIL flush_out_after: got v=%b occ=%0d want 0 0", out_valid, occupancy);
      end
      tick;
    end
  endtask

  task automatic test_depth1;
    int s = 0;
    logic acc;
    for (int c = 0; c < 20; c++) begin
      b_out_ready = (c % 2 == 0);
      b_in_valid = 1;
      for (int j = 0; j < NB; j++) begin
        b_din_i[j] = 9'(s*2 + j + 5);
        b_din_q[j] = 9'(-(s*2 + j) - 7);
      end
      @(negedge clk);
      acc = b_in_ready;
      nvec++;
      if (b_occupancy !== b_out_valid) begin
        nerr++; $display("FAIL d1_occ%0d: got occ=%0d want %0d", c, b_occupancy, b_out_valid);
      end
      tick;
      if (acc) s++;
    end
    b_in_valid = 0; b_out_ready = 1;
    repeat (3) tick;
    @(negedge clk);
    nvec++;
    if (sb_bi.size() != 0 || s != 10 || b_occupancy !== 1'b0) begin
      nerr++; $display("FAIL d1_drain: got pending=%0d accepted=%0d occ=%0d want 0 10 0",
                       sb_bi.size(), s, b_occupancy);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_full_stall;
    test_bubble;
    test_flush;
    test_depth1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish want finish before 500000");
    $fatal(1, "timeout");
  end
endmodule
